// File: rtl/hex_display_scheduler_pkg.sv
// hex_disp_pkg: segment constants, button code and state enums for the HEX display scheduler.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package hex_disp_pkg;

  // Active-low segment patterns, bit order g..a
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_N     = 7'b0101011;

  // Hex digits 0-F, entry n holds the pattern for nibble value n
  localparam logic [15:0][6:0] SEG_HEX = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  typedef enum logic [1:0] {
    BTN_NONE   = 2'd0,
    BTN_LEFT   = 2'd1,
    BTN_RIGHT  = 2'd2,
    BTN_MIDDLE = 2'd3
  } btn_code_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POS  = 2'd1,
    BTN  = 2'd2
  } state_e;

  // Glyph shown on hex3 for a latched button code
  function automatic logic [6:0] btn_glyph(input btn_code_e code);
    case (code)
      BTN_LEFT:   return SEG_L;
      BTN_RIGHT:  return SEG_R;
      BTN_MIDDLE: return SEG_N;
      default:    return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/hex_display_scheduler_if.sv
// hex_display_scheduler_if: strobe inputs and HEX outputs of the display scheduler.
// Latency: n/a (wires only).
// Backpressure: none; busy is status only, strobes are never refused.
interface hex_display_scheduler_if;

  logic       clear;
  logic       pos_valid;
  logic [7:0] pos_x;
  logic [7:0] pos_y;
  logic       btn_valid;
  logic [1:0] btn_code;
  logic       busy;
  logic [6:0] hex_0;
  logic [6:0] hex_1;
  logic [6:0] hex_2;
  logic [6:0] hex_3;

  // Cursor/mouse side
  modport master (
    output clear, pos_valid, pos_x, pos_y, btn_valid, btn_code,
    input  busy, hex_0, hex_1, hex_2, hex_3
  );

  // Scheduler side
  modport slave (
    input  clear, pos_valid, pos_x, pos_y, btn_valid, btn_code,
    output busy, hex_0, hex_1, hex_2, hex_3
  );

endinterface

// File: rtl/hex_display_scheduler_seg7_nibble.sv
// seg7_nibble: converts one 4-bit value to an active-low 7-segment pattern (g..a).
// Latency: combinational.
// Backpressure: none.
module seg7_nibble
  import hex_disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // Table lookup of the hex digit pattern
  always_comb begin
    seg = SEG_HEX[nib];
  end

endmodule

// File: rtl/hex_display_scheduler.sv
// hex_display_scheduler: shares HEX3..HEX0 between cursor position and a timed button glyph; HEX_BLINK_EN blinks the glyph.
// Latency: state/data load on the strobe edge, hex_* one edge later, busy combinational from state.
// Backpressure: none; every strobe is accepted, busy only reports the button hold.
module hex_display_scheduler
  import hex_disp_pkg::*;
#(
  parameter int HOLD_CYCLES  = 25_000_000,
  parameter int BLINK_CYCLES = 6_250_000
) (
  input  logic                    clk,
  input  logic                    reset,
  hex_display_scheduler_if.slave  bus
);

  localparam int              TW         = $clog2(HOLD_CYCLES);
  localparam logic [TW-1:0]   TIMER_LOAD = TW'(HOLD_CYCLES - 1);

  if (HOLD_CYCLES < 2 || BLINK_CYCLES < 1) begin : g_param_chk
    $error("hex_display_scheduler: HOLD_CYCLES must be >= 2 and BLINK_CYCLES >= 1");
  end

  state_e          state;
  logic [7:0]      cur_x;
  logic [7:0]      cur_y;
  logic            have_pos;
  logic [TW-1:0]   timer;
  btn_code_e       code_q;
  logic [6:0]      hex_0_q, hex_1_q, hex_2_q, hex_3_q;
  logic [6:0]      seg_x1, seg_x0, seg_y1, seg_y0;
  logic [6:0]      glyph_seg;
  logic            btn_hit;

  assign btn_hit = bus.btn_valid && (bus.btn_code != 2'd0);

  seg7_nibble u_seg_x1 (.nib(cur_x[7:4]), .seg(seg_x1));
  seg7_nibble u_seg_x0 (.nib(cur_x[3:0]), .seg(seg_x0));
  seg7_nibble u_seg_y1 (.nib(cur_y[7:4]), .seg(seg_y1));
  seg7_nibble u_seg_y0 (.nib(cur_y[3:0]), .seg(seg_y0));

`ifdef HEX_BLINK_EN
  localparam int            BW       = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  logic [BW-1:0] blink_cnt;
  logic          blink_off;

  // Blink phase: restarts on every button event, runs only while holding a glyph
  always_ff @(posedge clk) begin
    if (reset || bus.clear || btn_hit || state != BTN) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_off <= ~blink_off;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  // Glyph alternates with blank, glyph first
  always_comb begin
    glyph_seg = blink_off ? SEG_BLANK : btn_glyph(code_q);
  end
`else
  // Steady glyph
  always_comb begin
    glyph_seg = btn_glyph(code_q);
  end
`endif

  // Scheduler FSM with position/button capture and registered HEX outputs
  always_ff @(posedge clk) begin
    if (reset || bus.clear) begin
      state    <= IDLE;
      cur_x    <= '0;
      cur_y    <= '0;
      have_pos <= 1'b0;
      timer    <= '0;
      code_q   <= BTN_NONE;
      hex_0_q  <= SEG_DASH;
      hex_1_q  <= SEG_DASH;
      hex_2_q  <= SEG_DASH;
      hex_3_q  <= SEG_DASH;
    end else begin
      // Position is captured in every state; during BTN it waits for the hold to end
      if (bus.pos_valid) begin
        cur_x    <= bus.pos_x;
        cur_y    <= bus.pos_y;
        have_pos <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (btn_hit) begin
            state  <= BTN;
            code_q <= btn_code_e'(bus.btn_code);
            timer  <= TIMER_LOAD;
          end else if (bus.pos_valid) begin
            state <= POS;
          end
        end
        POS: begin
          if (btn_hit) begin
            state  <= BTN;
            code_q <= btn_code_e'(bus.btn_code);
            timer  <= TIMER_LOAD;
          end
        end
        BTN: begin
          if (btn_hit) begin
            code_q <= btn_code_e'(bus.btn_code);
            timer  <= TIMER_LOAD;
          end else if (timer == '0) begin
            state <= (have_pos || bus.pos_valid) ? POS : IDLE;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: state <= IDLE;
      endcase

      // Display follows the state/data held before this edge
      case (state)
        POS: begin
          hex_3_q <= seg_x1;
          hex_2_q <= seg_x0;
          hex_1_q <= seg_y1;
          hex_0_q <= seg_y0;
        end
        BTN: begin
          hex_3_q <= glyph_seg;
          hex_2_q <= SEG_DASH;
          hex_1_q <= SEG_DASH;
          hex_0_q <= SEG_DASH;
        end
        default: begin
          hex_3_q <= SEG_DASH;
          hex_2_q <= SEG_DASH;
          hex_1_q <= SEG_DASH;
          hex_0_q <= SEG_DASH;
        end
      endcase
    end
  end

  assign bus.busy  = (state == BTN);
  assign bus.hex_0 = hex_0_q;
  assign bus.hex_1 = hex_1_q;
  assign bus.hex_2 = hex_2_q;
  assign bus.hex_3 = hex_3_q;

endmodule

// File: tb/tb_hex_display_scheduler.sv
// tb_hex_display_scheduler: cycle-table bench for the HEX display scheduler (HOLD=4, BLINK=2).
// Latency: expectations are per edge, sampled 1 time unit after the rising edge.
// Backpressure: n/a.
module tb_hex_display_scheduler;

  localparam int HOLD  = 4;
  localparam int BLINK = 2;

  localparam logic [6:0] D  = 7'b0111111;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] GL = 7'b1000111;
  localparam logic [6:0] GR = 7'b0101111;
  localparam logic [6:0] GN = 7'b0101011;
  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SB = 7'b0000011;
  localparam logic [6:0] SC = 7'b1000110;
  localparam logic [6:0] SD = 7'b0100001;
  localparam logic [6:0] SE = 7'b0000110;
  localparam logic [6:0] SF = 7'b0001110;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  hex_display_scheduler_if bus ();

  hex_display_scheduler #(
    .HOLD_CYCLES (HOLD),
    .BLINK_CYCLES(BLINK)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic       clr;
    logic       pv;
    logic [7:0] x;
    logic [7:0] y;
    logic       bv;
    logic [1:0] code;
    logic       busy;
    logic [6:0] h3, h2, h1, h0;
    logic       blank3;   // hex3 is BLANK instead of the glyph when blinking
  } vec_t;

  typedef struct {
    logic       busy;
    logic [6:0] h3, h2, h1, h0;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(input logic clr, input logic pv, input logic [7:0] x,
                              input logic [7:0] y, input logic bv, input logic [1:0] code,
                              input logic busy, input logic [6:0] h3, input logic [6:0] h2,
                              input logic [6:0] h1, input logic [6:0] h0, input logic blank3);
    vec_t v;
    v.clr = clr; v.pv = pv; v.x = x; v.y = y; v.bv = bv; v.code = code;
    v.busy = busy; v.h3 = h3; v.h2 = h2; v.h1 = h1; v.h0 = h0; v.blank3 = blank3;
    return v;
  endfunction

  task automatic drive(input logic clr, input logic pv, input logic [7:0] x, input logic [7:0] y,
                       input logic bv, input logic [1:0] code);
    bus.clear     = clr;
    bus.pos_valid = pv;
    bus.pos_x     = x;
    bus.pos_y     = y;
    bus.btn_valid = bv;
    bus.btn_code  = code;
  endtask

  task automatic chk(input string nm, input int idx, input logic [6:0] got, input logic [6:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s step=%0d got=%b want=%b", nm, idx, got, want);
    end
  endtask

  task automatic chk_all(input string tag, input int idx, input exp_t e);
    chk({tag, ".busy"}, idx, {6'b0, bus.busy}, {6'b0, e.busy});
    chk({tag, ".hex3"}, idx, bus.hex_3, e.h3);
    chk({tag, ".hex2"}, idx, bus.hex_2, e.h2);
    chk({tag, ".hex1"}, idx, bus.hex_1, e.h1);
    chk({tag, ".hex0"}, idx, bus.hex_0, e.h0);
  endtask

  function automatic exp_t ex(input logic busy, input logic [6:0] h3, input logic [6:0] h2,
                              input logic [6:0] h1, input logic [6:0] h0);
    exp_t e;
    e.busy = busy; e.h3 = h3; e.h2 = h2; e.h1 = h1; e.h0 = h0;
    return e;
  endfunction

  initial begin
    vec_t v;
    exp_t e;
    logic [6:0] g3;

    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 2'd0);

    // Reset held two cycles with a position strobe present
    reset = 1'b1;
    drive(1'b0, 1'b1, 8'h3A, 8'hF1, 1'b0, 2'd0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk_all("reset", k, ex(1'b0, D, D, D, D));
    end
    reset = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 2'd0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk_all("post_reset", k, ex(1'b0, D, D, D, D));
    end

    // Per-edge table: inputs for the cycle, outputs after the edge
    //             clr  pv    x      y     bv  code  busy h3  h2  h1  h0  blank3
    vecs.push_back(mk(0, 1, 8'h3A, 8'hF1, 0, 2'd0, 0, D,  D,  D,  D,  0)); // 0 position
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 2'd0, 0, S3, SA, SF, S1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 2'd2, 1, S3, SA, SF, S1, 0)); // 2 right button
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 2'd0, 1, GR, D,  D,  D,  0));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 2'd0, 1, GR, D,  D,  D,  0));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 2'd0, 1, GR, D,  D,  D,  1));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 2'd0, 0, GR, D,  D,  D,  1));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 2'd0, 0, S3, SA, SF, S1, 0)); // 7 back to position
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 2'd1, 1, S3, SA, SF, S1, 0)); // 8 left button
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 2'd0, 1, GL, D,  D,  D,  0));
    vecs.push_back(mk(0, 1, 8'h00, 8'h07, 1, 2'd3, 1, GL, D,  D,  D,  0)); // 10 retrigger + capture
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 2'd0, 1, GN, D,  D,  D,  0));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 2'd0, 1, GN, D,  D,  D,  0));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 2'd0, 1, GN, D,  D,  D,  1));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 2'd0, 0, GN, D,  D,  D,  1));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 2'd0, 0, S0, S0, S0, S7, 0)); // 15 captured position
    vecs.push_back(mk(0, 1, 8'h23, 8'h45, 0, 2'd0, 0, S0, S0, S0, S7, 0));
    vecs.push_back(mk(0, 1, 8'h67, 8'h89, 0, 2'd0, 0, S2, S3, S4, S5, 0));
    vecs.push_back(mk(0, 1, 8'hBC, 8'hDE, 0, 2'd0, 0, S6, S7, S8, S9, 0));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 2'd0, 0, SB, SC, SD, SE, 0));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 2'd0, 0, SB, SC, SD, SE, 0)); // 20 code 0 ignored
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 2'd0, 0, SB, SC, SD, SE, 0));
    vecs.push_back(mk(1, 1, 8'h55, 8'h55, 1, 2'd2, 0, D,  D,  D,  D,  0)); // 22 clear wins
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 2'd0, 0, D,  D,  D,  D,  0));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 2'd0, 0, D,  D,  D,  D,  0)); // 24 code 0 in IDLE
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 2'd0, 0, D,  D,  D,  D,  0));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 2'd1, 1, D,  D,  D,  D,  0)); // 26 button, no position
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 2'd0, 1, GL, D,  D,  D,  0));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 2'd0, 1, GL, D,  D,  D,  0));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 2'd0, 1, GL, D,  D,  D,  1));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 2'd0, 0, GL, D,  D,  D,  1));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 2'd0, 0, D,  D,  D,  D,  0)); // 31 back to IDLE

    for (int i = 0; i < vecs.size(); i++) begin
      v  = vecs[i];
      g3 = v.h3;
`ifdef HEX_BLINK_EN
      if (v.blank3) g3 = BL;
`endif
      drive(v.clr, v.pv, v.x, v.y, v.bv, v.code);
      sb.push_back(ex(v.busy, g3, v.h2, v.h1, v.h0));
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 2'd0);
      e = sb.pop_front();
      chk_all("table", i, e);
    end

    // Reset during a button hold drops straight back to IDLE
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 2'd3);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 2'd0);
    chk("midbtn.busy", 0, {6'b0, bus.busy}, 7'd1);
    @(posedge clk); #1;
    chk("midbtn.hex3", 1, bus.hex_3, GN);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_all("midbtn_reset", 2, ex(1'b0, D, D, D, D));
    @(posedge clk); #1;
    chk_all("midbtn_after", 3, ex(1'b0, D, D, D, D));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
